// File: rtl/mu0_mem_resp.sv
// rtl/mu0_mem_resp.sv - MU0 memory responder: word array with programmable wait states and one-cycle Ack.
// Optional feature macro: MU0_MEM_RANGE_ERR_EN (adds Err for captured addresses >= DEPTH).
module mu0_mem_resp #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              Wr,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic              Ack,
   output logic [DATA_W-1:0] RData,
   output logic              Busy
`ifdef MU0_MEM_RANGE_ERR_EN
   ,
   output logic              Err
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              enter_ack;
   logic              cur_wr;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [IDX_W-1:0]  cur_idx;
   logic              oor;
   logic              mem_we;
   logic              addr_unused;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      enter_ack = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Req) begin
               wr_d    = Wr;
               addr_d  = Addr;
               wdata_d = WData;
               cnt_d   = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d   = S_ACK;
               enter_ack = 1'b1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states the access commits on the accepting edge, so the live inputs are used.
   assign cur_wr    = (state_q == S_IDLE) ? Wr    : wr_q;
   assign cur_addr  = (state_q == S_IDLE) ? Addr  : addr_q;
   assign cur_wdata = (state_q == S_IDLE) ? WData : wdata_q;
   assign cur_idx   = cur_addr[IDX_W-1:0];
   assign addr_unused = ^cur_addr;

`ifdef MU0_MEM_RANGE_ERR_EN
   logic err_q, err_d;
   assign oor   = ({1'b0, cur_addr} >= (ADDR_W+1)'(DEPTH));
   assign err_d = enter_ack & oor;
   assign Err   = err_q;
`else
   assign oor = 1'b0;
`endif

   assign mem_we = enter_ack & cur_wr & ~oor & Reset;

   always_comb begin
      rdata_d = rdata_q;
      if (enter_ack && !cur_wr) begin
         rdata_d = oor ? '0 : mem[cur_idx];
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MU0_MEM_RANGE_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef MU0_MEM_RANGE_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // Array contents survive reset.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   assign Ack   = (state_q == S_ACK);
   assign Busy  = (state_q != S_IDLE);
   assign RData = rdata_q;

endmodule

// File: tb/tb_mu0_mem_resp.sv
// tb/tb_mu0_mem_resp.sv - self-checking bench for mu0_mem_resp across three wait-state/depth configurations.
module tb_mu0_mem_resp;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [3];
   logic        req   [3];
   logic        wr    [3];
   logic [11:0] addr  [3];
   logic [15:0] wdata [3];
   logic        ack   [3];
   logic        busy  [3];
   logic [15:0] rdata [3];
`ifdef MU0_MEM_RANGE_ERR_EN
   logic        err_o [3];
`endif

   int vec = 0;
   int bad = 0;

   logic [15:0] mm    [3][4096];
   bit          mv    [3][4096];
   logic [15:0] last  [3];
   bit          lastv [3];

   mu0_mem_resp #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_STATES(1)) u_ws1 (
      .Clk(clk), .Reset(rst_n[0]), .Req(req[0]), .Wr(wr[0]), .Addr(addr[0]), .WData(wdata[0]),
      .Ack(ack[0]), .RData(rdata[0]), .Busy(busy[0])
`ifdef MU0_MEM_RANGE_ERR_EN
      , .Err(err_o[0])
`endif
   );

   mu0_mem_resp #(.ADDR_W(12), .DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .Clk(clk), .Reset(rst_n[1]), .Req(req[1]), .Wr(wr[1]), .Addr(addr[1]), .WData(wdata[1]),
      .Ack(ack[1]), .RData(rdata[1]), .Busy(busy[1])
`ifdef MU0_MEM_RANGE_ERR_EN
      , .Err(err_o[1])
`endif
   );

   mu0_mem_resp #(.ADDR_W(12), .DATA_W(16), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .Clk(clk), .Reset(rst_n[2]), .Req(req[2]), .Wr(wr[2]), .Addr(addr[2]), .WData(wdata[2]),
      .Ack(ack[2]), .RData(rdata[2]), .Busy(busy[2])
`ifdef MU0_MEM_RANGE_ERR_EN
      , .Err(err_o[2])
`endif
   );

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 3;
   endfunction

   function automatic int depth_of(input int k);
      return (k == 0) ? 4096 : 256;
   endfunction

   function automatic bit out_of_range(input int k, input logic [11:0] a);
`ifdef MU0_MEM_RANGE_ERR_EN
      return int'(a) >= depth_of(k);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model of one completed access: array indexed modulo depth, RData updated only by reads.
   task automatic model_access(input int k, input logic w, input logic [11:0] a, input logic [15:0] d,
                               output logic [15:0] exp_r, output bit expv);
      int idx;
      bit oor;
      idx = int'(a) % depth_of(k);
      oor = out_of_range(k, a);
      if (w) begin
         if (!oor) begin
            mm[k][idx] = d;
            mv[k][idx] = 1'b1;
         end
         exp_r = last[k];
         expv  = lastv[k];
      end else begin
         if (oor) begin
            exp_r = 16'h0000;
            expv  = 1'b1;
         end else begin
            exp_r = mm[k][idx];
            expv  = mv[k][idx];
         end
         last[k]  = exp_r;
         lastv[k] = expv;
      end
   endtask

   task automatic access(input int k, input logic w, input logic [11:0] a, input logic [15:0] d);
      int lat;
      bit got;
      logic [15:0] exp_r;
      bit expv;
      @(negedge clk);
      req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
      @(posedge clk);
      lat = 0; got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (ack[k] === 1'b1) begin
            got = 1'b1; lat = i;
         end else begin
            vec++;
            if (busy[k] !== 1'b1) begin
               bad++;
               $display("FAIL busy_wait k%0d cycle %0d got %b want 1", k, i, busy[k]);
            end
         end
      end
      req[k] = 1'b0;
      vec++;
      if (!got || lat != ws_of(k) + 1) begin
         bad++;
         $display("FAIL ack_latency k%0d addr %h got %0d (seen %0d) want %0d", k, a, lat, got, ws_of(k) + 1);
      end
      if (got) begin
         model_access(k, w, a, d, exp_r, expv);
         if (expv) begin
            vec++;
            if (rdata[k] !== exp_r) begin
               bad++;
               $display("FAIL rdata k%0d %s addr %h got %h want %h", k, w ? "wr" : "rd", a, rdata[k], exp_r);
            end
         end
`ifdef MU0_MEM_RANGE_ERR_EN
         vec++;
         if (err_o[k] !== out_of_range(k, a)) begin
            bad++;
            $display("FAIL err k%0d addr %h got %b want %b", k, a, err_o[k], out_of_range(k, a));
         end
`endif
      end
      @(negedge clk);
      vec++;
      if (ack[k] !== 1'b0 || busy[k] !== 1'b0) begin
         bad++;
         $display("FAIL ack_width k%0d got ack %b busy %b want 0 0", k, ack[k], busy[k]);
      end
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
         last[k] = 16'h0000; lastv[k] = 1'b1;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (ack[k] !== 1'b0 || busy[k] !== 1'b0 || rdata[k] !== 16'h0000) begin
            bad++;
            $display("FAIL reset k%0d got ack %b busy %b rdata %h want 0 0 0000", k, ack[k], busy[k], rdata[k]);
         end
`ifdef MU0_MEM_RANGE_ERR_EN
         vec++;
         if (err_o[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_err k%0d got %b want 0", k, err_o[k]);
         end
`endif
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
   endtask

   task automatic test_basic;
      access(0, 1'b1, 12'h005, 16'h1234);
      access(0, 1'b0, 12'h005, 16'h0000);
   endtask

   task automatic test_back_to_back(input int k, input logic [11:0] a, input logic [15:0] d);
      int t1, t2;
      logic [15:0] r1, r2, exp_r;
      bit expv;
      @(negedge clk);
      req[k] = 1'b1; wr[k] = 1'b1; addr[k] = a; wdata[k] = d;
      t1 = -1; t2 = -1; r1 = '0; r2 = '0;
      for (int i = 1; i <= 60 && t2 < 0; i++) begin
         @(negedge clk);
         if (ack[k] === 1'b1) begin
            if (t1 < 0) begin
               t1 = i; r1 = rdata[k]; wr[k] = 1'b0;
            end else begin
               t2 = i; r2 = rdata[k];
            end
         end
      end
      req[k] = 1'b0;
      vec++;
      if (t1 < 0 || t2 < 0 || t2 - t1 != ws_of(k) + 2) begin
         bad++;
         $display("FAIL b2b_spacing k%0d got %0d want %0d", k, t2 - t1, ws_of(k) + 2);
      end
      model_access(k, 1'b1, a, d, exp_r, expv);
      if (expv) begin
         vec++;
         if (r1 !== exp_r) begin
            bad++;
            $display("FAIL b2b_wr_rdata_hold k%0d got %h want %h", k, r1, exp_r);
         end
      end
      model_access(k, 1'b0, a, d, exp_r, expv);
      vec++;
      if (r2 !== exp_r) begin
         bad++;
         $display("FAIL b2b_read k%0d got %h want %h", k, r2, exp_r);
      end
      @(negedge clk);
      vec++;
      if (busy[k] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle k%0d got busy %b want 0", k, busy[k]);
      end
   endtask

   task automatic test_mid_change;
      int lat;
      logic [15:0] exp_r;
      bit expv;
      @(negedge clk);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 12'h020; wdata[2] = 16'h00AA;
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0; wr[2] = 1'b0; addr[2] = 12'h0FF; wdata[2] = 16'hFFFF;
      lat = 0;
      for (int i = 2; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (ack[2] === 1'b1) lat = i;
      end
      vec++;
      if (lat != ws_of(2) + 1) begin
         bad++;
         $display("FAIL mid_change_latency got %0d want %0d", lat, ws_of(2) + 1);
      end
      model_access(2, 1'b1, 12'h020, 16'h00AA, exp_r, expv);
      @(negedge clk);
      access(2, 1'b0, 12'h020, 16'h0000);
   endtask

   task automatic test_reset_abort;
      bit saw_ack;
      access(2, 1'b1, 12'h030, 16'h1111);
      @(negedge clk);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 12'h030; wdata[2] = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0;
      rst_n[2] = 1'b0;
      #1;
      vec++;
      if (busy[2] !== 1'b0 || ack[2] !== 1'b0 || rdata[2] !== 16'h0000) begin
         bad++;
         $display("FAIL reset_abort k2 got busy %b ack %b rdata %h want 0 0 0000", busy[2], ack[2], rdata[2]);
      end
      last[2] = 16'h0000; lastv[2] = 1'b1;
      @(negedge clk);
      rst_n[2] = 1'b1;
      saw_ack = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack[2] !== 1'b0 || busy[2] !== 1'b0) saw_ack = 1'b1;
      end
      vec++;
      if (saw_ack) begin
         bad++;
         $display("FAIL reset_abort_noack k2 got ack/busy activity want none");
      end
      access(2, 1'b0, 12'h030, 16'h0000);
   endtask

   task automatic test_wrap;
      access(1, 1'b1, 12'h005, 16'h1357);
      access(1, 1'b1, 12'h105, 16'h0ABC);
      access(1, 1'b0, 12'h005, 16'h0000);
      access(1, 1'b0, 12'h105, 16'h0000);
   endtask

   task automatic test_random(input int k, input int n);
      logic [11:0] a;
      logic [15:0] d;
      logic w;
      for (int i = 0; i < n; i++) begin
         a = 12'($urandom_range(0, 4095)) & 12'hF0F;
         d = 16'($urandom_range(0, 65535));
         w = 1'($urandom_range(0, 1));
         access(k, w, a, d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back(1, 12'h010, 16'hBEEF);
      test_back_to_back(0, 12'h011, 16'hC0DE);
      test_mid_change();
      test_reset_abort();
      test_wrap();
      test_random(0, 40);
      test_random(1, 40);
      test_random(2, 40);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
